// File: rtl/flow_pkg.sv
// Shared flow-control definitions: the command opcode encoding used by the
// flow stack unit and by the processor instruction decode.
package flow_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_CALL   = 3'd1,
    OP_RET    = 3'd2,
    OP_PUSHEN = 3'd3,
    OP_POPEN  = 3'd4,
    OP_ALLEN  = 3'd5,
    OP_JUMPF  = 3'd6,
    OP_RSVD   = 3'd7
  } flow_op_e;

endpackage : flow_pkg

// File: rtl/lifo_stack.sv
// Small register-based LIFO used as the subroutine return-address stack.
// Ports:
//   clk, reset      - clock, synchronous active-high reset (clears entries)
//   push, din       - write din on top; ignored when full
//   pop             - discard top entry; ignored when empty
//   top             - current top entry (zero when empty)
//   full, empty     - occupancy flags
//   count           - number of valid entries
module lifo_stack #(
  parameter  int W     = 16,
  parameter  int DEPTH = 4,
  localparam int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [W-1:0]    din,
  output logic [W-1:0]    top,
  output logic            full,
  output logic            empty,
  output logic [CNTW-1:0] count
);

  logic [W-1:0] mem [DEPTH];

  assign full  = (count == CNTW'(DEPTH));
  assign empty = (count == '0);

  // Entry i is the top when count == i+1.
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (count == CNTW'(i + 1)) top = mem[i];
    end
  end

  // NOTE: the storage is cleared on reset because software-visible state must
  // come up as all-zero; with only a handful of entries this costs nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (count == CNTW'(i)) mem[i] <= din;
      end
      count <= count + CNTW'(1);
    end else if (pop && !empty) begin
      count <= count - CNTW'(1);
    end
  end

endmodule : lifo_stack

// File: rtl/flow_stack_unit.sv
// Flow-control stack unit: subroutine call/return stack plus a predication
// (enable) bit stack with conditional-jump evaluation.
// Ports:
//   clk, reset               - clock, synchronous active-high reset
//   cmd_valid/cmd_ready      - command handshake; ready drops on any error
//   cmd_op, cmd_addr, cmd_cond - opcode (flow_pkg), CALL return address,
//                              JUMPF condition (register non-zero)
//   en_top                   - current enable bit
//   ret_valid, ret_addr      - one-cycle pulse with the popped return address
//   jump_take                - one-cycle pulse: JUMPF redirects the pc
//   call_depth, en_depth     - stack occupancies
//   overflow, underflow      - sticky error flags, cleared only by reset
module flow_stack_unit
  import flow_pkg::*;
#(
  parameter int AW     = 16,
  parameter int CDEPTH = 4,
  parameter int EDEPTH = 32,
  parameter int CW     = $clog2(CDEPTH + 1),
  parameter int EW     = $clog2(EDEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic          cmd_cond,
  output logic          en_top,
  output logic          ret_valid,
  output logic [AW-1:0] ret_addr,
  output logic          jump_take,
  output logic [CW-1:0] call_depth,
  output logic [EW-1:0] en_depth,
  output logic          overflow,
  output logic          underflow
);

  localparam int LCW = $clog2(CDEPTH + 1);

  flow_op_e          op;
  logic              accept;
  logic [EDEPTH-1:0] en_stack, en_stack_nxt;
  logic [EW-1:0]     en_depth_nxt;
  logic              call_push, call_pop;
  logic              set_ovf, set_unf;
  logic              ret_valid_nxt, jump_take_nxt;
  logic              stk_full, stk_empty;
  logic [AW-1:0]     stk_top;
  logic [LCW-1:0]    stk_count;

  assign cmd_ready  = ~(overflow | underflow);
  assign accept     = cmd_valid & cmd_ready;
  assign op         = flow_op_e'(cmd_op);
  assign en_top     = en_stack[0];
  assign call_depth = CW'(stk_count);

  lifo_stack #(
    .W     (AW),
    .DEPTH (CDEPTH)
  ) u_call_stack (
    .clk   (clk),
    .reset (reset),
    .push  (call_push),
    .pop   (call_pop),
    .din   (cmd_addr),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty),
    .count (stk_count)
  );

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    call_push     = 1'b0;
    call_pop      = 1'b0;
    set_ovf       = 1'b0;
    set_unf       = 1'b0;
    ret_valid_nxt = 1'b0;
    jump_take_nxt = 1'b0;
    en_stack_nxt  = en_stack;
    en_depth_nxt  = en_depth;
    if (accept) begin
      case (op)
        OP_CALL: begin
          // Calls in a disabled region are skipped entirely.
          if (en_stack[0]) begin
            if (stk_full) set_ovf   = 1'b1;
            else          call_push = 1'b1;
          end
        end
        OP_RET: begin
          if (en_stack[0]) begin
            if (stk_empty) begin
              set_unf = 1'b1;
            end else begin
              call_pop      = 1'b1;
              ret_valid_nxt = 1'b1;
            end
          end
        end
        OP_PUSHEN: begin
          if (en_depth == EW'(EDEPTH)) begin
            set_ovf = 1'b1;
          end else begin
            en_stack_nxt = {en_stack[EDEPTH-2:0], en_stack[0]};
            en_depth_nxt = en_depth + EW'(1);
          end
        end
        OP_POPEN: begin
          // The bottom entry is the outermost context and is never removed.
          if (en_depth == EW'(1)) begin
            set_unf = 1'b1;
          end else begin
            en_stack_nxt = {1'b0, en_stack[EDEPTH-1:1]};
            en_depth_nxt = en_depth - EW'(1);
          end
        end
        OP_ALLEN: en_stack_nxt[0] = 1'b1;
        OP_JUMPF: begin
          // A false condition disables the lanes; jump when the new top is 0.
          en_stack_nxt[0] = en_stack[0] & cmd_cond;
          jump_take_nxt   = ~(en_stack[0] & cmd_cond);
        end
        default: ;  // NOP and the reserved op have no effect
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_stack  <= EDEPTH'(1);
      en_depth  <= EW'(1);
      ret_valid <= 1'b0;
      ret_addr  <= '0;
      jump_take <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      en_stack  <= en_stack_nxt;
      en_depth  <= en_depth_nxt;
      ret_valid <= ret_valid_nxt;
      jump_take <= jump_take_nxt;
      overflow  <= overflow | set_ovf;
      underflow <= underflow | set_unf;
      if (call_pop) ret_addr <= stk_top;
    end
  end

endmodule : flow_stack_unit

// File: doc/flow_stack_unit.md
FLOW_STACK_UNIT -- requirements
Module: flow_stack_unit

Interface
REQ-001 Parameter AW, default 16, is the width of a program address (pc word).
REQ-002 Parameter CDEPTH, default 4, is the number of call stack entries.
REQ-003 Parameter EDEPTH, default 32, is the number of enable stack bits.
REQ-004 Parameter CW, default $clog2(CDEPTH+1), is the call depth counter width.
REQ-005 Parameter EW, default $clog2(EDEPTH+1), is the enable depth counter width.
REQ-006 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 Port cmd_valid, input, 1 bit: a command is presented.
REQ-009 Port cmd_ready, output, 1 bit: the unit accepts a command this cycle.
REQ-010 Port cmd_op, input, 3 bits: NOP=0, CALL=1, RET=2, PUSHEN=3, POPEN=4, ALLEN=5, JUMPF=6; 7 is reserved.
REQ-011 Port cmd_addr, input, AW bits: the return address pushed by CALL.
REQ-012 Port cmd_cond, input, 1 bit: the condition register-is-nonzero flag for JUMPF.
REQ-013 Port en_top, output, 1 bit: the current enable stack top bit.
REQ-014 Port ret_valid and ret_addr, outputs, 1 and AW bits: the popped return address, valid for one cycle.
REQ-015 Port jump_take, output, 1 bit: pulses for one cycle when a JUMPF must redirect the pc.
REQ-016 Ports call_depth (CW bits) and en_depth (EW bits), outputs: the current stack occupancies.
REQ-017 Ports overflow and underflow, outputs, 1 bit each: sticky error flags.

Function
REQ-018 A command is accepted when cmd_valid and cmd_ready are both high at a rising clk edge.
REQ-019 cmd_ready SHALL be high unless overflow or underflow is set.
REQ-020 All effects of an accepted command, and all outputs, SHALL be registered and visible the cycle after acceptance (latency 1).
REQ-021 CALL with en_top=1 and call_depth<CDEPTH SHALL push cmd_addr and increment call_depth.
REQ-022 CALL with en_top=0 SHALL change no state.
REQ-023 CALL with en_top=1 and call_depth==CDEPTH SHALL set overflow and leave the stack unchanged.
REQ-024 RET with en_top=1 and call_depth>0 SHALL pop the stack top to ret_addr, pulse ret_valid, and decrement call_depth.
REQ-025 RET with en_top=1 and call_depth==0 SHALL set underflow; RET with en_top=0 SHALL change no state.
REQ-026 PUSHEN SHALL duplicate the top bit (enable stack shifts left, bit0 kept) and increment en_depth.
REQ-027 PUSHEN at en_depth==EDEPTH SHALL set overflow and leave the enable stack unchanged.
REQ-028 POPEN SHALL shift the enable stack right and decrement en_depth.
REQ-029 POPEN at en_depth==1 SHALL set underflow; the bottom entry is never popped.
REQ-030 ALLEN SHALL set bit0 to 1 and leave en_depth unchanged.
REQ-031 JUMPF with cmd_cond=0 SHALL clear bit0; jump_take in the next cycle equals the new bit0 inverted.
REQ-032 NOP and the reserved op SHALL change no state; the reserved op is not an error.
REQ-033 With no accepted command, ret_valid and jump_take SHALL be 0.
REQ-034 Once set, overflow and underflow SHALL hold until reset, and no further command is accepted.

Reset
REQ-035 When reset is high at a clk edge, the following SHALL be cleared: call_depth=0, all call entries=0, enable stack=...0001, en_depth=1, en_top=1, ret_valid=0, ret_addr=0, jump_take=0, overflow=0, underflow=0.
REQ-036 Reset SHALL take priority over any simultaneous command, and a command in flight is discarded.

Structure
REQ-037 The opcode encodings for cmd_op SHALL reside in a shared package flow_pkg, reused by the processor decode.
REQ-038 The call stack SHALL be a sub-module lifo_stack (parameters W, DEPTH) exposing push, pop, top, full, and empty.
REQ-039 The enable stack SHALL be a shift register inside the top module.

Verification
REQ-040 Reset, then CALL 0x0123 and CALL 0x0456, then RET, RET -> ret_addr is 0x0456 then 0x0123, ret_valid pulses twice, and call_depth ends at 0.
REQ-041 CDEPTH=4: five CALLs with en_top=1 -> call_depth=4, overflow=1, cmd_ready=0, and the next RET is ignored.
REQ-042 PUSHEN, then JUMPF with cmd_cond=0 -> jump_take=1 and en_top=0; then CALL 0x0010 -> call_depth unchanged; then POPEN -> en_top=1 and en_depth=1.
REQ-043 POPEN at en_depth=1 -> underflow=1; then reset -> underflow=0 and cmd_ready=1.
REQ-044 JUMPF with cmd_cond=1 -> jump_take=0 and en_top=1; ALLEN after a cleared top -> en_top=1.
REQ-045 Reset asserted together with a CALL -> call_depth=0 and no push occurs.
